// File: rtl/layer_stream_driver.sv
// layer_stream_driver: word-serial front/back end for one fully connected layer.
// Ports: clk/rst, in_* input stream, layer_* parallel layer bus,
//        out_* output stream, busy, timeout_err (sticky).
module layer_stream_driver #(
  parameter int BIT_WIDTH      = 32,
  parameter int INPUT_SIZE     = 5,
  parameter int NUM_NEURONS    = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BIT_WIDTH-1:0]                   in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [INPUT_SIZE-1:0][BIT_WIDTH-1:0]   layer_inputs,
  output logic                                   layer_start,
  input  logic                                   layer_done,
  input  logic [NUM_NEURONS-1:0][BIT_WIDTH-1:0]  layer_outputs,
  output logic [BIT_WIDTH-1:0]                   out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int OW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IW-1:0] IN_LAST  = IW'(INPUT_SIZE - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [OW-1:0] out_idx_q, out_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [INPUT_SIZE-1:0][BIT_WIDTH-1:0]  lin_q, lin_d;
  logic [NUM_NEURONS-1:0][BIT_WIDTH-1:0] obuf_q, obuf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lin_q     <= '0;
      obuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lin_q     <= lin_d;
      obuf_q    <= obuf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    lin_d       = lin_q;
    obuf_d      = obuf_q;
    in_ready    = 1'b0;
    layer_start = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;

    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lin_d[in_idx_q] = in_data;
          if (in_idx_q == IN_LAST) begin
            in_idx_d = '0;
            state_d  = S_FIRE;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end

      S_FIRE: begin
        layer_start = 1'b1;
        done_d      = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        done_d = layer_done;
        // a done level held over from the previous run is not an edge
        if (layer_done && !done_q) begin
          obuf_d    = layer_outputs;
          out_idx_d = '0;
          state_d   = S_DRAIN;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = obuf_q[out_idx_q];
        out_last  = (out_idx_q == OUT_LAST);
        if (out_ready) begin
          if (out_idx_q == OUT_LAST) begin
            out_idx_d = '0;
            state_d   = S_LOAD;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  assign layer_inputs = lin_q;
  assign busy         = (state_q != S_LOAD);
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_layer_stream_driver.sv
// tb_layer_stream_driver: table-driven plus randomized frames for
// layer_stream_driver with a small reference of the layer handshake.
module tb_layer_stream_driver;

  localparam int BW = 32;
  localparam int NI = 3;
  localparam int NO = 2;
  localparam int TO = 8;

  logic                  clk;
  logic                  rst;
  logic [BW-1:0]         in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [NI-1:0][BW-1:0] layer_inputs;
  logic                  layer_start;
  logic                  layer_done;
  logic [NO-1:0][BW-1:0] layer_outputs;
  logic [BW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  timeout_err;

  layer_stream_driver #(
    .BIT_WIDTH      (BW),
    .INPUT_SIZE     (NI),
    .NUM_NEURONS    (NO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .layer_inputs  (layer_inputs),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .layer_outputs (layer_outputs),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0][BW-1:0] w;
    logic [NO-1:0][BW-1:0] o;
    int d;
    bit gaps;
    int rmode;
    int stall;
    bit stale;
    bit cap;
    bit err;
  } vec_t;

  localparam logic [NO-1:0][BW-1:0] JUNK = {NO{32'hDEADBEEF}};

  int   n_pass = 0;
  int   n_total = 0;
  bit   err_m;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, o0, o1,
                              input int d, input bit gaps,
                              input int rmode, input int stall,
                              input bit stale, input bit cap,
                              input bit err);
    vec_t r;
    r.w[0] = w0; r.w[1] = w1; r.w[2] = w2;
    r.o[0] = o0; r.o[1] = o1;
    r.d = d; r.gaps = gaps; r.rmode = rmode; r.stall = stall;
    r.stale = stale; r.cap = cap; r.err = err;
    return r;
  endfunction

  task automatic reset_check();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", layer_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_layer_inputs", layer_inputs, 0);
    #2;
    rst = 1'b1;
  endtask

  // layer model: done rises v.d cycles after the start cycle
  task automatic run_frame(input vec_t v, input bit abort);
    int k, g, j, cyc;
    bit acc, first;
    layer_done    = v.stale;
    layer_outputs = JUNK;
    out_ready     = 1'b0;
    k = 0;
    g = 0;
    while (k < NI && g < 64) begin
      chk("in_ready_load", in_ready, 1);
      in_data  = v.w[k];
      in_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid;
      step();
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (k < NI) begin
      chk("in_accept_guard", k, NI);
      return;
    end
    chk("start_pulse", layer_start, 1);
    chk("busy_fire", busy, 1);
    chk("in_ready_fire", in_ready, 0);
    chk("layer_inputs", layer_inputs, v.w);
    step();
    chk("start_single", layer_start, 0);
    for (int c = 1; c <= TO; c++) begin
      layer_done    = (c >= v.d);
      layer_outputs = layer_done ? v.o : JUNK;
      chk("wait_no_out", out_valid, 0);
      chk("wait_in_ready", in_ready, 0);
      step();
      if (c >= v.d) break;
    end
    layer_outputs = JUNK;
    if (!v.cap) begin
      chk("to_in_ready", in_ready, 1);
      chk("to_out_valid", out_valid, 0);
      chk("to_busy", busy, 0);
      chk("to_err", timeout_err, v.err);
      return;
    end
    if (abort) begin
      chk("abort_w0", out_data, v.o[0]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("abort_w1", out_data, v.o[1]);
      reset_check();
      return;
    end
    j = 0;
    cyc = 0;
    first = 1'b1;
    while (j < NO && cyc < 64) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, v.o[j]);
      chk("out_last", out_last, (j == NO - 1));
      if (first) chk("layer_inputs_hold", layer_inputs, v.w);
      first = 1'b0;
      unique case (v.rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc >= v.stall);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      acc = out_ready;
      step();
      if (acc) j++;
      cyc++;
    end
    out_ready = 1'b0;
    if (j < NO) chk("drain_guard", j, NO);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_err", timeout_err, v.err);
  endtask

  initial begin
    tbl[0] = mk(32'h8000, 32'h10000, 32'hFFFF8000, 32'h4000, 32'h0,
                3, 0, 0, 0, 0, 1, 0);
    tbl[1] = mk(32'h8000, 32'h10000, 32'hFFFF8000, 32'h4000, 32'h0,
                2, 1, 1, 4, 0, 1, 0);
    tbl[2] = mk(32'h1, 32'h2, 32'h3, 32'hAAAA, 32'hBBBB,
                3, 0, 0, 0, 1, 1, 0);
    tbl[3] = mk(32'h4, 32'h5, 32'h6, 32'h11, 32'h22,
                TO, 0, 0, 0, 1, 1, 0);
    tbl[4] = mk(32'h7, 32'h8, 32'h9, 32'h55, 32'h66,
                100, 0, 0, 0, 0, 0, 1);
    tbl[5] = mk(32'hA, 32'hB, 32'hC, 32'h33, 32'h44,
                4, 1, 2, 0, 0, 1, 1);

    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    layer_done = 1'b0;
    layer_outputs = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    step();
    step();
    chk("init_in_ready", in_ready, 1);
    chk("init_start", layer_start, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_last", out_last, 0);
    chk("init_busy", busy, 0);
    chk("init_err", timeout_err, 0);
    chk("init_out_data", out_data, 0);
    chk("init_layer_inputs", layer_inputs, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_frame(tbl[i], 1'b0);

    // reset after two of three input words
    in_valid = 1'b1;
    in_data = 32'h111;
    step();
    in_data = 32'h222;
    step();
    in_valid = 1'b0;
    chk("partial_busy", busy, 0);
    reset_check();
    step();
    run_frame(mk(32'h21, 32'h22, 32'h23, 32'h77, 32'h88,
                 2, 0, 0, 0, 0, 1, 0), 1'b0);

    // reset in the middle of a drain
    run_frame(mk(32'h31, 32'h32, 32'h33, 32'h99, 32'hAB,
                 3, 0, 0, 0, 0, 1, 0), 1'b1);
    step();
    run_frame(mk(32'h41, 32'h42, 32'h43, 32'hCD, 32'hEF,
                 2, 0, 0, 0, 0, 1, 0), 1'b0);

    err_m = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.stale = 1'($urandom_range(0, 1));
      v.d = v.stale ? int'($urandom_range(2, TO + 3))
                    : int'($urandom_range(1, TO + 3));
      for (int a = 0; a < NI; a++) v.w[a] = $urandom();
      for (int b = 0; b < NO; b++) v.o[b] = $urandom();
      v.gaps = 1'($urandom_range(0, 1));
      v.rmode = 2;
      v.stall = 0;
      v.cap = (v.d <= TO);
      err_m = err_m | !v.cap;
      v.err = err_m;
      run_frame(v, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/layer_stream_driver.md
# layer_stream_driver

Streaming front/back end for a single fully connected layer: collects an input vector word by word over a valid/ready stream and presents it to the layer's parallel input bus. It pulses the layer's `start`, waits for `done`, captures the parallel layer outputs, and replays them as a valid/ready output stream. It is the initiator/reader counterpart of the layer datapath and lets layers be chained or fed from a narrow bus.

## Interface
- `BIT_WIDTH`, 32, width of every data word (fixed point; the block does no arithmetic).
- `INPUT_SIZE`, 5, words per input vector.
- `NUM_NEURONS`, 5, words per output vector.
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent waiting for `layer_done`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  BIT_WIDTH  input stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  driver accepts a word.
- `layer_inputs`  out  BIT_WIDTH x INPUT_SIZE  parallel vector to the layer; index 0 = first word received.
- `layer_start`  out  1  one-cycle start pulse to the layer.
- `layer_done`  in  1  layer completion flag.
- `layer_outputs`  in  BIT_WIDTH x NUM_NEURONS  parallel layer result.
- `out_data`  out  BIT_WIDTH  output stream word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  marks the final word (index NUM_NEURONS-1).
- `busy`  out  1  high in FIRE, WAIT, DRAIN.
- `timeout_err`  out  1  sticky; set on a WAIT timeout, cleared only by reset.

## Operation
- States: LOAD, FIRE, WAIT, DRAIN. Reset state is LOAD.
- **LOAD:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, write `in_data` to `layer_inputs[in_idx]` and increment `in_idx`.
  - On the transfer with `in_idx == INPUT_SIZE-1`, clear `in_idx` and go to FIRE.
- **FIRE:**
  - `layer_start` = 1 for exactly this cycle.
  - Clear `done_q` and the timeout counter, then go to WAIT.
- **WAIT:**
  - Detect a `layer_done` rising edge: `layer_done == 1 && done_q == 0`, where `done_q` is `layer_done` registered each WAIT cycle.
  - On the edge, capture all `layer_outputs` into `obuf`, clear `out_idx`, go to DRAIN.
  - Otherwise, increment the counter. When it reaches `TIMEOUT_CYCLES-1`, set `timeout_err`, discard the vector, and go to LOAD.
  - If the edge and the timeout coincide, the edge wins and `timeout_err` is not set.
  - Layer contract: `layer_done` deasserts no later than the cycle after `layer_start`. A `done` level left high from a previous run is not an edge.
- **DRAIN:**
  - `out_valid` = 1, `out_data` = `obuf[out_idx]`, `out_last` = (`out_idx == NUM_NEURONS-1`).
  - On `out_valid && out_ready`, increment `out_idx`. On the last transfer, go to LOAD.
  - With `out_ready` = 0, `out_data`/`out_last` hold stable.
- `layer_inputs` is registered and changes only on LOAD transfers, so it is stable from FIRE through the end of WAIT and DRAIN.
- `in_ready` = 0 outside LOAD. Input words are never dropped or duplicated.
- **Asynchronous reset (`rst` low), any state:**
  - state = LOAD, all indices and counters = 0, `layer_inputs` = 0, `obuf` = 0, `timeout_err` = 0.
  - Partial input or output frames are discarded.

## Timing
- Reset values:
  - `in_ready` = 1 (LOAD).
  - `layer_start`, `out_valid`, `out_last`, `busy`, `timeout_err` = 0.
  - `out_data` = 0, `layer_inputs` = all 0.
- Last input accepted at cycle T: `layer_start` = 1 at T+1, WAIT from T+2.
- Best-case input throughput: one word per cycle.
- `done` edge sampled at cycle D: `out_valid` = 1 and `out_data` = `obuf[0]` at D+1.
- Output throughput: one word per cycle while `out_ready` = 1. Full drain takes NUM_NEURONS cycles.
- Last output accepted at cycle E: `in_ready` = 1 at E+1.
- Timeout: the cycle after entering WAIT plus TIMEOUT_CYCLES-1 cycles, then LOAD. `timeout_err` is visible the following cycle.
- Back-to-back vectors: no bubble beyond the FIRE cycle and the single LOAD re-entry cycle.

## Test plan
Bench parameters: INPUT_SIZE=3, NUM_NEURONS=2, TIMEOUT_CYCLES=8, BIT_WIDTH=32.

- **Basic frame:**
  - Stimulus: stream 0x8000, 0x10000, 0xFFFF8000 with `in_valid` held; layer model asserts `done` 3 cycles after start with outputs {0x4000, 0x0}.
  - Response: `layer_start` is a single-cycle pulse the cycle after the third word. `layer_inputs` = {0x8000, 0x10000, 0xFFFF8000}. Output stream is 0x4000 then 0x0, with `out_last` only on the second word.
- **Backpressure:**
  - Stimulus: `in_valid` toggled 1/0; `out_ready` low for 4 cycles in DRAIN.
  - Response: exactly 3 inputs accepted. `out_data` stays 0x4000 while stalled. No duplicated or lost words.
- **Stale done:**
  - Stimulus: `layer_done` held high from the previous run, dropping the cycle after start, rising 2 cycles later.
  - Response: capture happens only on the later rising edge.
- **Timeout:**
  - Stimulus: layer never asserts `done`.
  - Response: return to LOAD after 8 WAIT cycles. `timeout_err` = 1 and stays 1 through a subsequent good frame. `out_valid` never asserts for the failed frame.
- **Edge/timeout coincidence:**
  - Stimulus: `done` edge on the final WAIT cycle.
  - Response: outputs drained, `timeout_err` = 0.
- **Reset mid-frame:**
  - Stimulus: assert `rst` low after 2 inputs, and separately mid-DRAIN.
  - Response: all outputs return to reset values immediately. The next frame needs all 3 fresh words.
